vga_frame_capture: RTL

//  Receive side of the VGA link: samples an incoming 640x360 VGA stream (HS/VS + 4:4:4 RGB) on
//  the 25 MHz pixel strobe and writes one full frame into a frame-buffer sram write port.

---
 rtl/vga_frame_capture.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: one-shot capture of a VGA frame into a frame-buffer write port.
// Ports: CLK, i_rst, i_pix_stb, i_hs/i_vs, i_r/g/b, i_arm -> o_busy, o_we/o_addr/o_data, o_done, o_frame_err.
module vga_frame_capture #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 360,
    parameter int H_OFFSET   = 144,
    parameter int V_OFFSET   = 155,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  CLK,
    input  logic                  i_rst,
    input  logic                  i_pix_stb,
    input  logic                  i_hs,
    input  logic                  i_vs,
    input  logic [3:0]            i_r,
    input  logic [3:0]            i_g,
    input  logic [3:0]            i_b,
    input  logic                  i_arm,
    output logic                  o_busy,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [5:0]            o_data,
    output logic                  o_done,
    output logic                  o_frame_err
);

    localparam int DEPTH  = H_ACTIVE * V_ACTIVE;
    localparam int PIX_W  = $clog2(H_OFFSET + H_ACTIVE + 1);
    localparam int LINE_W = $clog2(V_OFFSET + V_ACTIVE + 1);

    localparam logic [PIX_W-1:0]      PIX_LO   = PIX_W'(H_OFFSET);
    localparam logic [PIX_W-1:0]      PIX_MAX  = PIX_W'(H_OFFSET + H_ACTIVE);
    localparam logic [LINE_W-1:0]     LINE_LO  = LINE_W'(V_OFFSET);
    localparam logic [LINE_W-1:0]     LINE_MAX = LINE_W'(V_OFFSET + V_ACTIVE);
    localparam logic [ADDR_WIDTH-1:0] PTR_END  = ADDR_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                  hs_q;
    logic                  vs_q;
    logic                  hs_edge;
    logic                  vs_edge;
    logic [PIX_W-1:0]      pix_cnt;
    logic [PIX_W-1:0]      pix_nxt;
    logic [LINE_W-1:0]     line_cnt;
    logic [LINE_W-1:0]     line_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  in_win;
    logic                  cnt_clr;
    logic                  cap_en;
    logic                  frame_err_d;
    logic                  unused_lsbs;

    assign unused_lsbs = ^{i_r[1:0], i_g[1:0], i_b[1:0]};

    // Edges compare the previous strobe's sync level with the current one.
    assign hs_edge = i_pix_stb & hs_q & ~i_hs;
    assign vs_edge = i_pix_stb & vs_q & ~i_vs;

    // Counter values that belong to the strobe being sampled now.
    always_comb begin
        pix_nxt  = pix_cnt;
        line_nxt = line_cnt;
        if (hs_edge) begin
            pix_nxt = '0;
            if (line_cnt != LINE_MAX) begin
                line_nxt = line_cnt + LINE_W'(1);
            end
        end else if (pix_cnt != PIX_MAX) begin
            pix_nxt = pix_cnt + PIX_W'(1);
        end
    end

    assign in_win = (line_nxt >= LINE_LO) && (line_nxt < LINE_MAX) &&
                    (pix_nxt >= PIX_LO) && (pix_nxt < PIX_MAX);

    always_ff @(posedge CLK) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        cap_en      = 1'b0;
        frame_err_d = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_arm) begin
                    state_d = WAIT_VS;
                end
            end
            WAIT_VS: begin
                o_busy = 1'b1;
                if (vs_edge) begin
                    state_d = CAPTURE;
                    cnt_clr = 1'b1;
                end
            end
            CAPTURE: begin
                o_busy = 1'b1;
                if (wr_ptr == PTR_END) begin
                    state_d = DONE;
                end else if (vs_edge) begin
                    // Frame restarted before all pixels arrived.
                    cnt_clr     = 1'b1;
                    frame_err_d = 1'b1;
                end else begin
                    cap_en = 1'b1;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (i_rst) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            wr_ptr      <= '0;
            o_we        <= 1'b0;
            o_addr      <= '0;
            o_data      <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_we        <= 1'b0;
            o_frame_err <= frame_err_d;
            if (i_pix_stb) begin
                hs_q <= i_hs;
                vs_q <= i_vs;
            end
            if (cnt_clr) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
                wr_ptr   <= '0;
            end else if (cap_en && i_pix_stb) begin
                pix_cnt  <= pix_nxt;
                line_cnt <= line_nxt;
                if (in_win) begin
                    o_we   <= 1'b1;
                    o_addr <= wr_ptr;
                    o_data <= {i_r[3:2], i_g[3:2], i_b[3:2]};
                    wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule
